// File: rtl/double_to_float_if.sv
// ============================================================================
// Module   : double_to_float_if
// Brief    : Strobe/acknowledge bundle for the double-to-float converter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface double_to_float_if;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a,
    output input_a_stb,
    input  input_a_ack,
    input  output_z,
    input  output_z_stb,
    output output_z_ack
  );

  modport slave (
    input  input_a,
    input  input_a_stb,
    output input_a_ack,
    output output_z,
    output output_z_stb,
    input  output_z_ack
  );
endinterface

`default_nettype wire

// File: rtl/double_to_float.sv
// ============================================================================
// Module   : double_to_float
// Brief    : Multi-cycle IEEE-754 double to single converter, round to nearest
//            even. Define DOUBLE_TO_FLOAT_DENORMAL_EN to produce single
//            denormals; otherwise tiny results flush to signed zero.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module double_to_float (
  input  logic              clk,
  input  logic              rst,
  double_to_float_if.slave  bus
);

  localparam logic [2:0] GET_A  = 3'd0;
  localparam logic [2:0] UNPACK = 3'd1;
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
  localparam logic [2:0] DENORM = 3'd2;
`endif
  localparam logic [2:0] ROUND  = 3'd3;
  localparam logic [2:0] PACK   = 3'd4;
  localparam logic [2:0] PUT_Z  = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic               r_ack;
  logic               r_stb;
  logic [31:0]        r_z;
  logic [63:0]        r_a;
  logic               r_s;
  logic signed [11:0] r_e;
  logic [23:0]        r_man;
  logic               r_g;
  logic               r_r;
  logic               r_sticky;
  logic               r_special;
  logic [31:0]        r_res;
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
  logic [4:0]         r_k;
  logic [4:0]         w_k_next;
  logic signed [11:0] w_shift;
  logic [4:0]         w_k;
`endif

  logic               w_ack_next;
  logic               w_stb_next;
  logic [31:0]        w_z_next;
  logic [63:0]        w_a_next;
  logic               w_s_next;
  logic signed [11:0] w_e_next;
  logic [23:0]        w_man_next;
  logic               w_g_next;
  logic               w_r_next;
  logic               w_sticky_next;
  logic               w_special_next;
  logic [31:0]        w_res_next;

  // Operand decode, consumed in UNPACK
  logic [10:0]        w_e;
  logic signed [11:0] w_ea;
  logic               w_frac_nz;
  logic               w_big;
  logic               w_tiny;
  logic               w_special;
  logic [31:0]        w_special_res;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_round_up;
  logic [24:0]        w_sum;
  logic [7:0]         w_exp_field;

  assign w_e       = r_a[62:52];
  assign w_ea      = $signed({1'b0, w_e}) - 12'sd1023;
  assign w_frac_nz = |r_a[51:0];
  assign w_big     = (w_ea > 12'sd127);
  assign w_tiny    = (w_ea < -12'sd126);

`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
  assign w_special = (w_e == 11'h7FF) || (w_e == 11'd0) || w_big;
  assign w_shift   = -12'sd126 - w_ea;
  assign w_k       = (w_shift > 12'sd26) ? 5'd26 : w_shift[4:0];
`else
  assign w_special = (w_e == 11'h7FF) || (w_e == 11'd0) || w_big || w_tiny;
`endif

  always_comb begin
    w_special_res = {r_a[63], 31'd0};
    if (w_e == 11'h7FF)
      w_special_res = w_frac_nz ? {r_a[63], 8'hFF, 23'h400000} : {r_a[63], 8'hFF, 23'd0};
    else if (w_e == 11'd0)
      w_special_res = {r_a[63], 31'd0};
    else if (w_big)
      w_special_res = {r_a[63], 8'hFF, 23'd0};
  end

  assign w_in_xfer   = r_ack && bus.input_a_stb;
  assign w_out_xfer  = r_stb && bus.output_z_ack;
  assign w_round_up  = r_g && (r_r || r_sticky || r_man[0]);
  assign w_sum       = {1'b0, r_man} + 25'd1;
  // A leading zero after denormal shifting means an exponent field of zero
  assign w_exp_field = r_man[23] ? (r_e[7:0] + 8'd127) : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= GET_A;
      r_ack     <= 1'b0;
      r_stb     <= 1'b0;
      r_z       <= 32'd0;
      r_a       <= 64'd0;
      r_s       <= 1'b0;
      r_e       <= 12'sd0;
      r_man     <= 24'd0;
      r_g       <= 1'b0;
      r_r       <= 1'b0;
      r_sticky  <= 1'b0;
      r_special <= 1'b0;
      r_res     <= 32'd0;
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
      r_k       <= 5'd0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_ack     <= w_ack_next;
      r_stb     <= w_stb_next;
      r_z       <= w_z_next;
      r_a       <= w_a_next;
      r_s       <= w_s_next;
      r_e       <= w_e_next;
      r_man     <= w_man_next;
      r_g       <= w_g_next;
      r_r       <= w_r_next;
      r_sticky  <= w_sticky_next;
      r_special <= w_special_next;
      r_res     <= w_res_next;
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
      r_k       <= w_k_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      GET_A:  if (w_in_xfer) w_state_next = UNPACK;
      UNPACK: begin
        if (w_special)
          w_state_next = PACK;
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
        else if (w_tiny)
          w_state_next = DENORM;
`endif
        else
          w_state_next = ROUND;
      end
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
      DENORM: if (r_k == 5'd1) w_state_next = ROUND;
`endif
      ROUND:  w_state_next = PACK;
      PACK:   w_state_next = PUT_Z;
      PUT_Z:  if (w_out_xfer) w_state_next = GET_A;
      default: w_state_next = GET_A;
    endcase
  end

  always_comb begin
    w_ack_next     = (w_state_next == GET_A);
    w_stb_next     = (w_state_next == PUT_Z);
    w_z_next       = r_z;
    w_a_next       = r_a;
    w_s_next       = r_s;
    w_e_next       = r_e;
    w_man_next     = r_man;
    w_g_next       = r_g;
    w_r_next       = r_r;
    w_sticky_next  = r_sticky;
    w_special_next = r_special;
    w_res_next     = r_res;
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
    w_k_next       = r_k;
`endif
    case (r_state)
      GET_A: begin
        if (w_in_xfer) w_a_next = bus.input_a;
      end
      UNPACK: begin
        w_s_next       = r_a[63];
        w_e_next       = w_ea;
        w_man_next     = {1'b1, r_a[51:29]};
        w_g_next       = r_a[28];
        w_r_next       = r_a[27];
        w_sticky_next  = |r_a[26:0];
        w_special_next = w_special;
        w_res_next     = w_special_res;
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
        if (!w_special && w_tiny) begin
          w_e_next = -12'sd126;
          w_k_next = w_k;
        end
`endif
      end
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
      DENORM: begin
        w_man_next    = {1'b0, r_man[23:1]};
        w_g_next      = r_man[0];
        w_r_next      = r_g;
        w_sticky_next = r_sticky | r_r;
        w_k_next      = r_k - 5'd1;
      end
`endif
      ROUND: begin
        if (w_round_up) begin
          if (w_sum[24]) begin
            w_man_next = w_sum[24:1];
            w_e_next   = r_e + 12'sd1;
            if (r_e == 12'sd127) begin
              w_special_next = 1'b1;
              w_res_next     = {r_s, 8'hFF, 23'd0};
            end
          end else begin
            w_man_next = w_sum[23:0];
          end
        end
      end
      PACK: begin
        w_z_next = r_special ? r_res : {r_s, w_exp_field, r_man[22:0]};
      end
      default: ;
    endcase
  end

  assign bus.input_a_ack  = r_ack;
  assign bus.output_z_stb = r_stb;
  assign bus.output_z     = r_z;

endmodule

`default_nettype wire

// File: tb/tb_double_to_float.sv
// ============================================================================
// Module   : tb_double_to_float
// Brief    : Directed-vector bench for double_to_float.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_double_to_float;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  double_to_float_if bus ();

  double_to_float dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one operand and return the accept-to-stb latency; stb left high
  task automatic send(input logic [63:0] a, output int lat);
    int cnt;
    @(negedge clk);
    bus.input_a     = a;
    bus.input_a_stb = 1'b1;
    cnt = 0;
    while (!bus.input_a_ack && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("accept_ready", {63'd0, bus.input_a_ack}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.input_a_stb = 1'b0;
    bus.input_a     = 64'hDEAD_BEEF_DEAD_BEEF;
    lat = 1;
    while (!bus.output_z_stb && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    bus.output_z_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.output_z_ack = 1'b0;
    check("stb_cleared", {63'd0, bus.output_z_stb}, 64'd0);
  endtask

  task automatic convert(input string tag, input logic [63:0] a, input logic [31:0] exp_z,
                         input int exp_lat, input int hold);
    int lat;
    send(a, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_z"}, {32'd0, bus.output_z}, {32'd0, exp_z});
    check({tag, "_ack_low"}, {63'd0, bus.input_a_ack}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_stb"}, {63'd0, bus.output_z_stb}, 64'd1);
      check({tag, "_hold_z"}, {32'd0, bus.output_z}, {32'd0, exp_z});
    end
    take();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat_tiny;
    int lat_half;
    logic [31:0] z_tiny;
    logic [31:0] z_half;
`ifdef DOUBLE_TO_FLOAT_DENORMAL_EN
    lat_tiny = 27;
    lat_half = 5;
    z_tiny   = 32'h00000001;
    z_half   = 32'h00400000;
`else
    lat_tiny = 3;
    lat_half = 3;
    z_tiny   = 32'h00000000;
    z_half   = 32'h00000000;
`endif
    bus.input_a      = 64'd0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;

    #1;
    check("rst_ack", {63'd0, bus.input_a_ack}, 64'd0);
    check("rst_stb", {63'd0, bus.output_z_stb}, 64'd0);
    check("rst_z", {32'd0, bus.output_z}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ack_after_rst", {63'd0, bus.input_a_ack}, 64'd1);

    convert("one",        64'h3FF0000000000000, 32'h3F800000, 4, 0);
    convert("tie_even",   64'h3FF0000010000000, 32'h3F800000, 4, 0);
    convert("tie_up",     64'h3FF0000030000000, 32'h3F800002, 4, 0);
    convert("ovf",        64'h47F0000000000000, 32'h7F800000, 3, 0);
    convert("ovf_carry",  64'h47EFFFFFF0000000, 32'h7F800000, 4, 0);
    convert("qnan",       64'h7FF8000000000000, 32'h7FC00000, 3, 0);
    convert("neg_inf",    64'hFFF0000000000000, 32'hFF800000, 3, 0);
    convert("neg_dzero",  64'h8000000000000001, 32'h80000000, 3, 0);
    convert("denorm_min", 64'h36A0000000000000, z_tiny, lat_tiny, 0);
    convert("denorm_half",64'h3800000000000000, z_half, lat_half, 0);
    convert("backpress",  64'hC000000000000000, 32'hC0000000, 4, 10);

    // Reset two edges after accept: mid-DENORM when denormals are enabled
    begin
      int cnt;
      @(negedge clk);
      bus.input_a     = 64'h36A0000000000000;
      bus.input_a_stb = 1'b1;
      cnt = 0;
      while (!bus.input_a_ack && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      check("rst_mid_accept", {63'd0, bus.input_a_ack}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.input_a_stb = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_stb", {63'd0, bus.output_z_stb}, 64'd0);
      check("rst_mid_z", {32'd0, bus.output_z}, 64'd0);
      check("rst_mid_ack", {63'd0, bus.input_a_ack}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_ack_rise", {63'd0, bus.input_a_ack}, 64'd1);
    end

    convert("after_rst",  64'h3FF0000000000000, 32'h3F800000, 4, 0);
    convert("neg_two_p",  64'hC00C000000000000, 32'hC0600000, 4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
